// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - shared decode-stage constants, bus widths and decoded-op enumeration
// Bus width helpers take XLEN so every pipeline stage derives identical layouts:
//   fs bus  : {pc, inst}
//   ds bus  : {op, is_word, funct3, rs1_val, rs2_val, imm, dest, pc, illegal}
//   fwd bus : {valid, we, dest, is_load, data}
package id_stage_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_ILLEGAL
  } dec_op_e;

  function automatic int fs_bus_w(input int xlen);
    return xlen + 32;
  endfunction

  function automatic int ds_bus_w(input int xlen);
    return 4 * xlen + 15;
  endfunction

  function automatic int fwd_bus_w(input int xlen);
    return xlen + 8;
  endfunction

  // alt selects SUB/SRA; callers only raise it where funct7[5] is meaningful
  function automatic dec_op_e alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// rtl/id_stage_regfile.sv - NREG x XLEN register file, 2 async reads, 1 sync write
// Ports: clk_i/reset_i; raddr1_i/raddr2_i -> rdata1_o/rdata2_o; we_i/waddr_i/wdata_i write port.
// x0 always reads zero; a read of the address being written returns the write data.
module id_stage_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [$clog2(NREG)-1:0] raddr1_i,
  input  logic [$clog2(NREG)-1:0] raddr2_i,
  output logic [XLEN-1:0]         rdata1_o,
  output logic [XLEN-1:0]         rdata2_o,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [XLEN-1:0]         wdata_i
);

  logic [XLEN-1:0] regs_q [NREG];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 :
                    (we_i && (waddr_i == raddr1_i)) ? wdata_i : regs_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 :
                    (we_i && (waddr_i == raddr2_i)) ? wdata_i : regs_q[raddr2_i];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: pipeline register, decode, operand read/forward, branch resolve
// Ports: clk/reset; fs_to_ds_valid/fs_to_ds_bus/ds_allowin from fetch; ds_to_es_valid/
// ds_to_es_bus/es_allowin to execute; br_bus {taken, target} to fetch; es/ms_fwd_bus producer
// info; ws_we/ws_waddr/ws_wdata register write-back.
// Macro ID_BYPASS_EN: defined -> forward es > ms > ws, stall only on an es load; undefined ->
// stall on any RAW hazard against es, ms or the current ws write.
module id_stage
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      fs_to_ds_valid,
  input  logic [fs_bus_w(XLEN)-1:0] fs_to_ds_bus,
  output logic                      ds_allowin,
  output logic                      ds_to_es_valid,
  output logic [ds_bus_w(XLEN)-1:0] ds_to_es_bus,
  input  logic                      es_allowin,
  output logic [XLEN:0]             br_bus,
  input  logic [fwd_bus_w(XLEN)-1:0] es_fwd_bus,
  input  logic [fwd_bus_w(XLEN)-1:0] ms_fwd_bus,
  input  logic                      ws_we,
  input  logic [$clog2(NREG)-1:0]   ws_waddr,
  input  logic [XLEN-1:0]           ws_wdata
);

  localparam int FS_BUS_W = fs_bus_w(XLEN);
  localparam int AW       = $clog2(NREG);

  logic                ds_valid_q, ds_valid_d;
  logic [FS_BUS_W-1:0] ds_bus_q, ds_bus_d;
  logic                ds_ready_go, br_taken, cond;
  logic [XLEN-1:0]     br_target, pc, imm;
  logic [31:0]         inst;

  assign {pc, inst} = ds_bus_q;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2, dest;
  logic [2:0] f3;
  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));

  dec_op_e op;
  logic    is_word, illegal, use_rs1, use_rs2, writes_rd;

  always_comb begin
    op        = OP_ADD;
    is_word   = 1'b0;
    illegal   = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    imm       = '0;
    case (opcode)
      OPC_LUI:    begin op = OP_LUI;   imm = imm_u; writes_rd = 1'b1; end
      OPC_AUIPC:  begin op = OP_AUIPC; imm = imm_u; writes_rd = 1'b1; end
      OPC_JAL:    begin op = OP_JAL;   imm = imm_j; writes_rd = 1'b1; end
      OPC_JALR: begin
        op = OP_JALR; imm = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1;
        illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        op = OP_BRANCH; imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
        illegal = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LOAD:   begin op = OP_LOAD;  imm = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1; end
      OPC_STORE:  begin op = OP_STORE; imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        // only the shift-right immediate form carries an alt bit in funct7
        op = alu_op(f3, (f3 == 3'b101) && inst[30]);
        imm = imm_i; use_rs1 = 1'b1; writes_rd = 1'b1;
        is_word = (opcode == OPC_OP_IMM_32);
        illegal = is_word && (XLEN != 64);
      end
      OPC_OP, OPC_OP_32: begin
        op = alu_op(f3, inst[30]);
        use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
        is_word = (opcode == OPC_OP_32);
        illegal = is_word && (XLEN != 64);
      end
      default: begin op = OP_ILLEGAL; illegal = 1'b1; end
    endcase
    if ((use_rs1 && (32'(rs1) >= NREG)) || (use_rs2 && (32'(rs2) >= NREG)) ||
        (writes_rd && (32'(rd) >= NREG)))
      illegal = 1'b1;
  end

  assign dest = writes_rd ? rd : 5'd0;

  logic [1:0][XLEN-1:0] rf_val, opnd;
  logic [1:0][4:0]      src;
  logic [1:0]           src_used, src_stall;

  assign src      = {rs2, rs1};
  assign src_used = {use_rs2, use_rs1};

  id_stage_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clk_i    (clk),
    .reset_i  (reset),
    .raddr1_i (rs1[AW-1:0]),
    .raddr2_i (rs2[AW-1:0]),
    .rdata1_o (rf_val[0]),
    .rdata2_o (rf_val[1]),
    .we_i     (ws_we),
    .waddr_i  (ws_waddr),
    .wdata_i  (ws_wdata)
  );

  logic            es_v, es_we, es_ld, ms_v, ms_we, ms_ld;
  logic [4:0]      es_dest, ms_dest;
  logic [XLEN-1:0] es_data, ms_data;
  assign {es_v, es_we, es_dest, es_ld, es_data} = es_fwd_bus;
  assign {ms_v, ms_we, ms_dest, ms_ld, ms_data} = ms_fwd_bus;

  for (genvar k = 0; k < 2; k++) begin : g_src
    logic es_hit, ms_hit, ws_hit;
    assign es_hit = src_used[k] && (src[k] != 5'd0) && es_v && es_we && (es_dest == src[k]);
    assign ms_hit = src_used[k] && (src[k] != 5'd0) && ms_v && ms_we && (ms_dest == src[k]);
    assign ws_hit = src_used[k] && (src[k] != 5'd0) && ws_we && (5'(ws_waddr) == src[k]);
`ifdef ID_BYPASS_EN
    assign src_stall[k] = es_hit && es_ld;
    assign opnd[k] = es_hit ? es_data : ms_hit ? ms_data : ws_hit ? ws_wdata : rf_val[k];
`else
    assign src_stall[k] = es_hit || ms_hit || ws_hit;
    assign opnd[k] = rf_val[k];
`endif
  end

`ifdef ID_BYPASS_EN
  logic unused_fwd;
  assign unused_fwd = ms_ld;
`else
  logic unused_fwd;
  assign unused_fwd = ^{es_ld, ms_ld, es_data, ms_data};
`endif

  assign ds_ready_go = ~|src_stall;

  always_comb begin
    cond = 1'b0;
    if ((op == OP_JAL) || (op == OP_JALR)) begin
      cond = 1'b1;
    end else if (op == OP_BRANCH) begin
      case (f3)
        3'b000:  cond = (opnd[0] == opnd[1]);
        3'b001:  cond = (opnd[0] != opnd[1]);
        3'b100:  cond = ($signed(opnd[0]) < $signed(opnd[1]));
        3'b101:  cond = ($signed(opnd[0]) >= $signed(opnd[1]));
        3'b110:  cond = (opnd[0] < opnd[1]);
        3'b111:  cond = (opnd[0] >= opnd[1]);
        default: cond = 1'b0;
      endcase
    end
    if (illegal) cond = 1'b0;
  end

  assign br_taken  = ds_valid_q && ds_ready_go && es_allowin && cond;
  assign br_target = (op == OP_JALR) ? ((opnd[0] + imm) & ~XLEN'(1)) : (pc + imm);
  assign br_bus    = {br_taken, br_target};

  assign ds_allowin     = !ds_valid_q || (ds_ready_go && es_allowin);
  assign ds_to_es_valid = ds_valid_q && ds_ready_go;
  assign ds_to_es_bus   = {op, is_word, f3, opnd[0], opnd[1], imm, dest, pc, illegal};

  // A taken branch squashes whatever fetch presents in the same cycle.
  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_bus_d   = ds_bus_q;
    if (ds_allowin) ds_valid_d = fs_to_ds_valid && !br_taken;
    if (fs_to_ds_valid && ds_allowin) ds_bus_d = fs_to_ds_bus;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      ds_bus_q   <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_bus_q   <= ds_bus_d;
    end
  end

endmodule
